cla_nibble_seq: RTL and testbench

// - Sequencer that computes WIDTH-bit add (and optionally subtract) on one shared 4-bit carry-lookahead adder slice.
// - Feeds one nibble per cycle, LSB first, and registers carry between nibbles.
// - Sits between a valid/ready operand source and the combinational 4-bit CLA.
// - Collects the result and presents it on a valid/ready output port.

---
 rtl/cla_nibble_seq.sv | 141 ++++++++++++++
 tb/tb_cla_nibble_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: computes a WIDTH-bit add on one shared external 4-bit
// carry-lookahead slice. The slice sees one nibble per cycle, LSB first, and
// the carry between nibbles is held in a register.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high, ena is high and rst_n is high. Once valid is raised, the
// source holds its payload until that edge.
//
// Optional feature: define CLA_SEQ_SUB_EN to add the op_sub input (A-B) and
// the ovf output (signed overflow of the final nibble).
//
// dbg_state shows the FSM state (0 IDLE, 1 RUN, 2 DONE) so checkers can bind to it.
module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
`ifdef CLA_SEQ_SUB_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  carry_q;
    logic [NIB-1:0][3:0]   a_q;
    logic [NIB-1:0][3:0]   b_q;
    logic [NIB-1:0][3:0]   sum_q;
    logic                  cout_q;
    logic                  ovf_q;
    logic                  carry_into_msb;

    // Next-state logic; ena gating lives in the register process.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; the adder inputs are zero outside RUN.
    always_comb begin
        in_ready  = ena && (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    // The sum bit is a^b^c, so the carry into the top bit of the slice can be
    // recovered from the slice's own inputs and its sum output.
    assign carry_into_msb = add_sum[3] ^ add_a[3] ^ add_b[3];

    // State, operand, carry and result registers; ena=0 freezes all of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_in;
                        idx_q <= '0;
`ifdef CLA_SEQ_SUB_EN
                        b_q     <= op_sub ? ~b_in : b_in;
                        carry_q <= op_sub ? 1'b1 : cin_in;
`else
                        b_q     <= b_in;
                        carry_q <= cin_in;
`endif
                    end
                end
                S_RUN: begin
                    sum_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= add_cout;
                        ovf_q  <= carry_into_msb ^ add_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_out   = sum_q;
    assign cout_out  = cout_q;
    assign dbg_state = state_q;
`ifdef CLA_SEQ_SUB_EN
    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq (WIDTH=16) with an ideal 4-bit CLA attached.
// A scoreboard queue holds {ovf, cout, sum} computed with whole-word
// arithmetic when each operand pair is issued; a monitor pops on each
// output handshake.
module tb_cla_nibble_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cin_in = 1'b0;
  logic             op_sub = 1'b0;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf;
  logic [1:0]       dbg_state;

  cla_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
`ifdef CLA_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
`ifdef CLA_SEQ_SUB_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

`ifndef CLA_SEQ_SUB_EN
  assign ovf = 1'b0;
`endif

  // Ideal combinational 4-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  // ---------------- scoreboard ----------------
  logic [WIDTH+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an output handshake happens at the next posedge.
  always @(negedge clk) begin
    if (rst_n && ena && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(1), 32'(0));
      end else begin
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(sum_out), 32'(e[WIDTH-1:0]));
        check("cout", 32'(cout_out), 32'(e[WIDTH]));
`ifdef CLA_SEQ_SUB_EN
        check("ovf", 32'(ovf), 32'(e[WIDTH+1]));
`endif
      end
    end
  end

  // Reference result from whole-word arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             c;
    logic [WIDTH:0]   r;
    logic             v;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
    v  = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return {v, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the accept posedge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int n;
    logic sub;
`ifdef CLA_SEQ_SUB_EN
    sub = op_sub;
`else
    sub = 1'b0;
`endif
    a_in = a; b_in = b; cin_in = cin; in_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (n == 200) begin
      check("send_timeout", 32'(1), 32'(0));
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(a, b, cin, sub));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts accept-inclusive edges until out_valid; returns at a negedge.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) return;
      @(posedge clk); #1;
      lat++;
    end
    check("valid_timeout", 32'(1), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [WIDTH+1:0] e;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             c0;
  int lat;
  bit done;

  initial begin
    // Reset and reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum_out), 32'(0));
    check("rst_cout", 32'(cout_out), 32'(0));
    check("rst_add_a", 32'(add_a), 32'(0));
    @(posedge clk); #1 ena = 1'b0;
    @(negedge clk);
    check("ena0_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1 ena = 1'b1;

    // Basic add with latency.
    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(1, lat);
    check("basic_latency", 32'(lat), 32'(NIB + 1));
    check("basic_sum_const", 32'(sum_out), 32'h5555);
    @(posedge clk); #1;

    // Full ripple: carry register is 1 after each nibble.
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < NIB; i++) begin
      @(negedge clk);
      check("ripple_add_cin", 32'(add_cin), (i == 0) ? 32'(0) : 32'(1));
      @(posedge clk); #1;
    end
    wait_valid(0, lat);
    check("ripple_sum_const", 32'(sum_out), 32'h0000);
    check("ripple_cout_const", 32'(cout_out), 32'(1));
    @(posedge clk); #1;

    // Backpressure for 3 cycles in DONE.
    out_ready = 1'b0;
    send(16'h8765, 16'h9ABC, 1'b1);
    e = model(16'h8765, 16'h9ABC, 1'b1, 1'b0);
    wait_valid(1, lat);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_sum_held", 32'(sum_out), 32'(e[WIDTH-1:0]));
      check("bp_cout_held", 32'(cout_out), 32'(e[WIDTH]));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'(0));
    check("bp_release_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    send(16'h0F0F, 16'h00F1, 1'b0);
    wait_valid(1, lat);
    check("after_bp_latency", 32'(lat), 32'(NIB + 1));
    @(posedge clk); #1;

    // Reset at RUN idx=2 aborts the operation.
    send(16'h7777, 16'h1111, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_sum", 32'(sum_out), 32'(0));
    check("midrst_add_a", 32'(add_a), 32'(0));
    check("midrst_add_b", 32'(add_b), 32'(0));
    check("midrst_add_cin", 32'(add_cin), 32'(0));
    @(posedge clk); #1;

    // ena stall for 2 cycles at RUN idx=1.
    ra = 16'hA5C3; rb = 16'h3C7E;
    c0 = ((ra[3:0] + rb[3:0] + 5'd1) > 5'd15);
    send(ra, rb, 1'b1);
    @(posedge clk); #1 ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_add_a", 32'(add_a), 32'(ra[7:4]));
      check("stall_add_cin", 32'(add_cin), 32'(c0));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    ena = 1'b1;
    wait_valid(4, lat);
    check("stall_latency", 32'(lat), 32'(NIB + 1 + 2));
    @(posedge clk); #1;

`ifdef CLA_SEQ_SUB_EN
    op_sub = 1'b1;
    send(16'h0005, 16'h0007, 1'b0);
    wait_valid(1, lat);
    check("sub1_sum_const", 32'(sum_out), 32'hFFFE);
    @(posedge clk); #1;
    send(16'h8000, 16'h0001, 1'b0);
    wait_valid(1, lat);
    check("sub2_ovf_const", 32'(ovf), 32'(1));
    @(posedge clk); #1;
    op_sub = 1'b0;
`endif

    // Random operands with random backpressure and ena gaps.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
`ifdef CLA_SEQ_SUB_EN
          op_sub = 1'($urandom_range(0, 1));
`endif
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          ena       = ($urandom_range(0, 7) != 0);
        end
      end
    join
    @(posedge clk); #1;
    ena = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
